sdram_wrbuf_be: RTL and testbench
=================================

Name: sdram_wrbuf_be

Overview:
Parametrised byte-enable write buffer between the chipset/CPU write path and the SDRAM controller. It queues write transactions (address, byte enables, data) in an inferred two-port RAM with byte-lane write enables. Back-to-back writes to the same address are coalesced into the newest queued entry. The SDRAM side drains entries through a registered valid/ack output stage.

Parameters:
AW, 22, transaction address width (word address)
DW, 16, data width; must be a multiple of 8; BE = DW/8 byte lanes
DEPTH_LOG2, 4, log2 of entry count; DEPTH = 2**DEPTH_LOG2

Ports:
clock  in  1  single clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
merge_en  in  1  enables write coalescing
wr_req  in  1  write request
wr_ack  out  BE-independent 1  combinational accept: !full | merge_hit
wr_addr  in  AW  write word address
wr_be  in  BE  byte enables, bit i = data[8i+7:8i]
wr_data  in  DW  write data
rd_valid  out  1  output stage holds an entry
rd_ack  in  1  consumer pops output entry when rd_valid
rd_addr  out  AW  address of output entry
rd_be  out  BE  merged byte enables of output entry
rd_data  out  DW  data of output entry (disabled lanes undefined)
level  out  DEPTH_LOG2+1  accepted, not yet popped entries
empty  out  1  level == 0
full  out  1  level == DEPTH

Behaviour:
- Reset (async, reset_n low): pointers, level, pending and rd_valid = 0; empty = 1; full = 0; rd_addr, rd_be = 0. rd_data is RAM-sourced and unspecified. Reset mid-burst discards all entries. The first clock edge after release is a normal cycle.
- Storage: data lives in BE byte-lane memories. A lane is written only when its wr_be bit is set. Address and be arrays are flops.
- Pointers: wr_ptr (next free slot) and pf_ptr (next slot to prefetch), both DEPTH_LOG2 wide and wrapping modulo DEPTH. pending = entries written but not yet prefetched.
- Push occurs when wr_req & wr_ack & !merge_hit:
  - write slot wr_ptr: lanes per wr_be, addr, be = wr_be
  - wr_ptr+1, level+1, pending+1
- merge_hit requires all of:
  - merge_en & wr_req
  - pending >= 1
  - wr_addr == addr[wr_ptr-1]
  - the prefetch is not taking the tail slot this cycle (pending == 1 & prefetch fire)
- On merge_hit:
  - enabled lanes of slot wr_ptr-1 are overwritten
  - be[wr_ptr-1] |= wr_be
  - level and pointers are unchanged
  - merging is accepted even when full
- Prefetch fire: pending >= 1 and (!rd_valid | rd_ack). On fire:
  - RAM read issued at pf_ptr
  - pf_ptr+1, pending-1
  - next edge: rd_valid = 1; rd_addr and rd_be are captured from the flop arrays in the same cycle as the read, so they align with rd_data
  - if pending == 0 and rd_ack, rd_valid goes 0
- Pop (rd_valid & rd_ack): level-1. The slot becomes reusable only after the pop, so the output entry counts in level.
- Latency: a push accepted at edge N gives rd_valid = 1 after edge N+1 when the buffer was empty. This gives a throughput of one entry per clock with a continuous rd_ack.
- Simultaneous push and pop: level unchanged. full is evaluated before the pop, so a non-merging write at full is refused (wr_ack = 0) even with rd_ack = 1.
- A write is never lost: wr_ack = 0 means the request must be held.
- rd_ack while !rd_valid is ignored.
- level, empty and full are registered and update on the edge after the push/pop.

Test Plan:
- Reset, then push (addr 0x000100, be 2'b11, data 0x1234) at edge 1 -> rd_valid high after edge 2; rd_addr = 0x000100, rd_be = 2'b11, rd_data = 0x1234; level = 1; pop -> empty = 1, level = 0.
- Fill with DEPTH = 16 distinct writes and no rd_ack -> full = 1 after 16th push; 17th wr_req to a new addr gets wr_ack = 0; drain returns all 16 in order with correct data across pointer wrap (start at wr_ptr = 14).
- merge_en = 1:
  - write addr 0x20 be 2'b01 data 0x00AA, then the next cycle addr 0x20 be 2'b10 data 0xBB00
  - required: a single entry with rd_be = 2'b11, rd_data = 0xBBAA, level = 1
  - repeat with merge_en = 0 -> two entries
- Merge race: buffer empty with rd_valid=0; push addr 0x40, then next cycle (prefetch firing on that slot) write addr 0x40 -> no merge, two entries appear in order.
- Full plus merge: at full, write to the tail address with be 2'b10 -> wr_ack = 1, level stays 16, tail rd_be gains bit 1.
- Assert reset_n low asynchronously mid-drain with level = 5 -> rd_valid, level = 0 and empty = 1 immediately; after release, a new push is output correctly.

Source files
------------

// File: rtl/sdram_wrbuf_be.sv
// sdram_wrbuf_be: byte-enable write buffer sitting in front of the SDRAM controller.
// Queues (address, byte enables, data) entries in per-lane RAMs, coalesces a write
// into the newest queued entry when it targets the same address, and presents
// entries to the SDRAM side through a registered valid/ack output stage.
module sdram_wrbuf_be #(
    parameter int AW         = 22,
    parameter int DW         = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  merge_en,
    input  logic                  wr_req,
    output logic                  wr_ack,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DW/8-1:0]       wr_be,
    input  logic [DW-1:0]         wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ack,
    output logic [AW-1:0]         rd_addr,
    output logic [DW/8-1:0]       rd_be,
    output logic [DW-1:0]         rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full
);

    localparam int BE    = DW / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    localparam ptr_t PTR_ONE  = ptr_t'(1);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

    // Address and byte-enable arrays are plain flops; data lives in lane RAMs.
    logic [AW-1:0] addr_mem [DEPTH];
    logic [BE-1:0] be_mem   [DEPTH];

    ptr_t wr_ptr;
    ptr_t pf_ptr;
    ptr_t tail_ptr;
    ptr_t wslot;
    cnt_t pending;
    cnt_t level_nxt;

    logic pend_nz;
    logic pf_fire;
    logic pop;
    logic merge_hit;
    logic push;
    logic wr_en;

    // Handshake decode: prefetch, pop, merge detection, accept and push.
    always_comb begin
        tail_ptr  = wr_ptr - PTR_ONE;
        pend_nz   = (pending != '0);
        pf_fire   = pend_nz & (~rd_valid | rd_ack);
        pop       = rd_valid & rd_ack;
        // The tail slot cannot be merged into while it is being read out this cycle.
        merge_hit = merge_en & wr_req & pend_nz
                  & (wr_addr == addr_mem[tail_ptr])
                  & ~((pending == CNT_ONE) & pf_fire);
        wr_ack    = ~full | merge_hit;
        push      = wr_req & wr_ack & ~merge_hit;
        wr_en     = push | merge_hit;
        wslot     = merge_hit ? tail_ptr : wr_ptr;
    end

    // Next occupancy: output-stage entry still counts until it is popped.
    always_comb begin
        level_nxt = level;
        unique case ({push, pop})
            2'b10:   level_nxt = level + CNT_ONE;
            2'b01:   level_nxt = level - CNT_ONE;
            default: level_nxt = level;
        endcase
    end

    // Per-lane data RAMs: lane written only when its enable is set, registered read.
    for (genvar i = 0; i < BE; i++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_q;

        // Lane write on push/merge, lane read on prefetch.
        always_ff @(posedge clock) begin
            if (wr_en && wr_be[i]) begin
                lane_mem[wslot] <= wr_data[8*i +: 8];
            end
            if (pf_fire) begin
                lane_q <= lane_mem[pf_ptr];
            end
        end

        assign rd_data[8*i +: 8] = lane_q;
    end

    // Address/byte-enable arrays: fresh entry on push, OR-in enables on merge.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[wr_ptr] <= wr_addr;
            be_mem[wr_ptr]   <= wr_be;
        end else if (merge_hit) begin
            be_mem[tail_ptr] <= be_mem[tail_ptr] | wr_be;
        end
    end

    // Pointers and pending count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            pf_ptr  <= '0;
            pending <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pf_fire) begin
                pf_ptr <= pf_ptr + PTR_ONE;
            end
            unique case ({push, pf_fire})
                2'b10:   pending <= pending + CNT_ONE;
                2'b01:   pending <= pending - CNT_ONE;
                default: pending <= pending;
            endcase
        end
    end

    // Registered occupancy flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            level <= level_nxt;
            empty <= (level_nxt == '0);
            full  <= (level_nxt == CNT_FULL);
        end
    end

    // Output stage: address/enables captured alongside the lane RAM read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            rd_be    <= '0;
        end else if (pf_fire) begin
            rd_valid <= 1'b1;
            rd_addr  <= addr_mem[pf_ptr];
            rd_be    <= be_mem[pf_ptr];
        end else if (pop) begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdram_wrbuf_be.sv
// tb_sdram_wrbuf_be: directed stimulus against a queue-level model of the write buffer,
// with a per-cycle compare process plus hand-computed literal checks.
module tb_sdram_wrbuf_be;

    logic        clock;
    logic        reset_n;
    logic        merge_en;
    logic        wr_req;
    logic        wr_ack;
    logic [21:0] wr_addr;
    logic [1:0]  wr_be;
    logic [15:0] wr_data;
    logic        rd_valid;
    logic        rd_ack;
    logic [21:0] rd_addr;
    logic [1:0]  rd_be;
    logic [15:0] rd_data;
    logic [4:0]  level;
    logic        empty;
    logic        full;

    sdram_wrbuf_be #(.AW(22), .DW(16), .DEPTH_LOG2(4)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .merge_en (merge_en),
        .wr_req   (wr_req),
        .wr_ack   (wr_ack),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ack   (rd_ack),
        .rd_addr  (rd_addr),
        .rd_be    (rd_be),
        .rd_data  (rd_data),
        .level    (level),
        .empty    (empty),
        .full     (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    bit run   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model: entries not yet in the output stage, plus the output stage itself.
    typedef struct {
        logic [21:0] a;
        logic [1:0]  be;
        logic [15:0] d;
    } ent_t;

    ent_t st[$];
    ent_t ov;
    bit   ov_valid = 0;

    always @(negedge reset_n) begin
        st.delete();
        ov_valid = 0;
    end

    always @(negedge clock) begin : cmp
        int          n;
        int          lvl;
        bit          fire;
        bit          hit;
        bit          acc;
        bit          pop;
        logic [15:0] mask;
        ent_t        e;
        if (reset_n && run) begin
            n   = st.size();
            lvl = n + int'(ov_valid);
            chk("rd_valid", rd_valid, ov_valid);
            if (ov_valid) begin
                mask = {{8{ov.be[1]}}, {8{ov.be[0]}}};
                chk("rd_addr", rd_addr, ov.a);
                chk("rd_be", rd_be, ov.be);
                chk("rd_data", rd_data & mask, ov.d & mask);
            end
            chk("level", level, lvl);
            chk("empty", empty, lvl == 0);
            chk("full", full, lvl == 16);
            fire = (n > 0) && (!ov_valid || rd_ack);
            hit  = merge_en && wr_req && (n > 0) && (wr_addr == st[n-1].a) && !(n == 1 && fire);
            acc  = (lvl != 16) || hit;
            chk("wr_ack", wr_ack, acc);
            pop  = ov_valid && rd_ack;
            if (hit) begin
                e = st[n-1];
                e.be = e.be | wr_be;
                for (int b = 0; b < 2; b++) begin
                    if (wr_be[b]) e.d[8*b +: 8] = wr_data[8*b +: 8];
                end
                st[n-1] = e;
            end
            if (fire) begin
                ov = st.pop_front();
                ov_valid = 1;
            end else if (pop) begin
                ov_valid = 0;
            end
            if (wr_req && acc && !hit) begin
                e.a = wr_addr;
                e.be = wr_be;
                e.d = wr_data;
                st.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [21:0] a, input logic [1:0] be, input logic [15:0] d);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_be   = be;
        wr_data = d;
    endtask

    task automatic idle();
        wr_req = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        merge_en = 1'b0;
        wr_req   = 1'b0;
        rd_ack   = 1'b0;
        wr_addr  = '0;
        wr_be    = '0;
        wr_data  = '0;
        #22;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rd_be", rd_be, 0);
        reset_n = 1'b1;
        run = 1;
        step();

        // Single push: visible one edge after acceptance.
        wr(22'h000100, 2'b11, 16'h1234);
        step();
        idle();
        step();
        chk("t1_valid", rd_valid, 1);
        chk("t1_addr", rd_addr, 22'h000100);
        chk("t1_be", rd_be, 2'b11);
        chk("t1_data", rd_data, 16'h1234);
        chk("t1_level", level, 1);
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        chk("t1_empty", empty, 1);
        chk("t1_level0", level, 0);

        // Advance wr_ptr to 14 with streaming traffic.
        rd_ack = 1'b1;
        for (int i = 0; i < 13; i++) begin
            wr(22'h000500 + 22'(i), 2'b11, 16'h5500 + 16'(i));
            step();
        end
        idle();
        repeat (3) step();
        rd_ack = 1'b0;
        chk("pre_empty", empty, 1);

        // Fill to DEPTH across the pointer wrap.
        for (int i = 0; i < 16; i++) begin
            wr(22'h001000 + 22'(i), (i == 15) ? 2'b01 : 2'b11, 16'h3C00 + 16'(i));
            step();
        end
        chk("fill_full", full, 1);
        chk("fill_level", level, 16);
        wr(22'h002000, 2'b11, 16'hDEAD);
        #1;
        chk("full_refuse", wr_ack, 0);
        step();
        merge_en = 1'b1;
        wr(22'h00100F, 2'b10, 16'h5A00);
        #1;
        chk("full_merge_ack", wr_ack, 1);
        step();
        idle();
        merge_en = 1'b0;
        chk("full_merge_level", level, 16);
        rd_ack = 1'b1;
        repeat (15) step();
        chk("tail_valid", rd_valid, 1);
        chk("tail_addr", rd_addr, 22'h00100F);
        chk("tail_be", rd_be, 2'b11);
        chk("tail_data", rd_data, 16'h5A0F);
        step();
        rd_ack = 1'b0;
        chk("drain_empty", empty, 1);

        // Coalescing behind an occupied output stage, then the same without merging.
        for (int m = 1; m >= 0; m--) begin
            merge_en = (m == 1);
            wr(22'h000010, 2'b11, 16'h1010);
            step();
            wr(22'h000020, 2'b01, 16'h00AA);
            step();
            wr(22'h000020, 2'b10, 16'hBB00);
            step();
            idle();
            chk("mrg_level", level, (m == 1) ? 2 : 3);
            rd_ack = 1'b1;
            step();
            rd_ack = 1'b0;
            if (m == 1) begin
                chk("mrg_addr", rd_addr, 22'h000020);
                chk("mrg_be", rd_be, 2'b11);
                chk("mrg_data", rd_data, 16'hBBAA);
                chk("mrg_level1", level, 1);
            end else begin
                chk("nomrg_be", rd_be, 2'b01);
                chk("nomrg_level2", level, 2);
            end
            rd_ack = 1'b1;
            repeat (2) step();
            rd_ack = 1'b0;
            chk("mrg_empty", empty, 1);
        end

        // Merge race: tail slot is being prefetched, so the second write is a new entry.
        merge_en = 1'b1;
        wr(22'h000040, 2'b01, 16'h0011);
        step();
        wr(22'h000040, 2'b10, 16'h2200);
        step();
        idle();
        merge_en = 1'b0;
        chk("race_level", level, 2);
        chk("race_be0", rd_be, 2'b01);
        rd_ack = 1'b1;
        step();
        chk("race_be1", rd_be, 2'b10);
        chk("race_data1", rd_data & 16'hFF00, 16'h2200);
        step();
        rd_ack = 1'b0;
        chk("race_empty", empty, 1);

        // Asynchronous reset mid-drain.
        for (int i = 0; i < 7; i++) begin
            wr(22'h000300 + 22'(i), 2'b11, 16'h7000 + 16'(i));
            step();
        end
        idle();
        rd_ack = 1'b1;
        repeat (2) step();
        chk("pre_rst_level", level, 5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", rd_valid, 0);
        chk("arst_level", level, 0);
        chk("arst_empty", empty, 1);
        rd_ack = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        wr(22'h000077, 2'b11, 16'hCAFE);
        step();
        idle();
        step();
        chk("post_valid", rd_valid, 1);
        chk("post_addr", rd_addr, 22'h000077);
        chk("post_data", rd_data, 16'hCAFE);
        chk("post_level", level, 1);
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
